// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: widths, table entry layout and reset value
// used by the rename/ARF block and its lookup slices.
package rv32i_types;

    localparam int NUM_ARCH_REGS      = 32;
    localparam int DATA_WIDTH         = 32;
    localparam int ROB_IDX_WIDTH      = 5;
    localparam int ARCH_REG_IDX_WIDTH = $clog2(NUM_ARCH_REGS);
    localparam int DISPATCH_WIDTH     = 2;
    localparam int COMMIT_WIDTH       = 2;

    typedef logic [ARCH_REG_IDX_WIDTH-1:0] arch_reg_t;
    typedef logic [ROB_IDX_WIDTH-1:0]      rob_idx_t;
    typedef logic [DATA_WIDTH-1:0]         data_t;

    // One alias-table entry: committed value, whether it is current, and the
    // ROB tag of the latest in-flight writer when it is not.
    typedef struct packed {
        data_t    data;
        logic     ready;
        rob_idx_t rob_idx;
    } rat_entry_t;

    localparam rat_entry_t RAT_ENTRY_RESET = '{data: '0, ready: 1'b1, rob_idx: '0};

endpackage

// File: rtl/rat_src_lookup.sv
// Operand lookup for one source of one dispatch slot. Resolves, in order:
// x0, an older writer in the same dispatch group, a same-cycle commit of the
// awaited tag, and finally the stored table entry.
module rat_src_lookup
    import rv32i_types::*;
#(
    parameter int SLOT = 0
) (
    input  arch_reg_t                      src,
    input  rat_entry_t                     entry,
    input  logic [DISPATCH_WIDTH-1:0]      disp_valid,
    input  arch_reg_t [DISPATCH_WIDTH-1:0] disp_rd,
    input  rob_idx_t  [DISPATCH_WIDTH-1:0] disp_rob_idx,
    input  logic [COMMIT_WIDTH-1:0]        cmt_valid,
    input  arch_reg_t [COMMIT_WIDTH-1:0]   cmt_rd,
    input  rob_idx_t  [COMMIT_WIDTH-1:0]   cmt_rob_idx,
    input  data_t     [COMMIT_WIDTH-1:0]   cmt_data,
    output logic                           rdy,
    output rob_idx_t                       tag,
    output data_t                          data
);

    // Priority resolution: each later step overrides the earlier ones.
    always_comb begin
        // NOTE: combinational blocks use blocking assignments with defaults
        // first, so every path assigns every output and no latch is inferred.
        rdy  = entry.ready;
        tag  = entry.rob_idx;
        data = entry.data;

        // Commit of the exact tag the entry waits on makes it ready now.
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (cmt_valid[k] && (cmt_rd[k] == src) && !entry.ready &&
                (cmt_rob_idx[k] == entry.rob_idx)) begin
                rdy  = 1'b1;
                data = cmt_data[k];
            end
        end

        // Older slot in this group renaming the source; youngest wins.
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            if ((i < SLOT) && disp_valid[i] && (disp_rd[i] == src) &&
                (src != '0)) begin
                rdy = 1'b0;
                tag = disp_rob_idx[i];
            end
        end

        if (src == '0) begin
            rdy  = 1'b1;
            tag  = '0;
            data = '0;
        end
    end

endmodule

// File: rtl/rat_arf_superscalar.sv
// Register alias table fused with the architectural register file. Renames
// up to DISPATCH_WIDTH instructions and retires up to COMMIT_WIDTH results
// per cycle; readiness is tracked by matching the latest writer's ROB tag.
module rat_arf_superscalar
    import rv32i_types::*;
(
    input  logic                                                     clk,
    input  logic                                                     rst,
    input  logic [DISPATCH_WIDTH-1:0]                                disp_valid,
    input  logic [DISPATCH_WIDTH-1:0][ARCH_REG_IDX_WIDTH-1:0]        disp_rs1,
    input  logic [DISPATCH_WIDTH-1:0][ARCH_REG_IDX_WIDTH-1:0]        disp_rs2,
    input  logic [DISPATCH_WIDTH-1:0][ARCH_REG_IDX_WIDTH-1:0]        disp_rd,
    input  logic [DISPATCH_WIDTH-1:0][ROB_IDX_WIDTH-1:0]             disp_rob_idx,
    input  logic [COMMIT_WIDTH-1:0]                                  cmt_valid,
    input  logic [COMMIT_WIDTH-1:0][ARCH_REG_IDX_WIDTH-1:0]          cmt_rd,
    input  logic [COMMIT_WIDTH-1:0][ROB_IDX_WIDTH-1:0]               cmt_rob_idx,
    input  logic [COMMIT_WIDTH-1:0][DATA_WIDTH-1:0]                  cmt_data,
    input  logic                                                     flush,
    output logic [DISPATCH_WIDTH-1:0][1:0]                           src_rdy,
    output logic [DISPATCH_WIDTH-1:0][1:0][ROB_IDX_WIDTH-1:0]        src_tag,
    output logic [DISPATCH_WIDTH-1:0][1:0][DATA_WIDTH-1:0]           src_data
);

    rat_entry_t rat_q [NUM_ARCH_REGS];
    rat_entry_t rat_d [NUM_ARCH_REGS];

    // Two lookup slices per dispatch slot: index 0 is rs1, index 1 is rs2.
    for (genvar j = 0; j < DISPATCH_WIDTH; j++) begin : g_slot
        rat_src_lookup #(.SLOT(j)) u_rs1 (
            .src          (disp_rs1[j]),
            .entry        (rat_q[disp_rs1[j]]),
            .disp_valid   (disp_valid),
            .disp_rd      (disp_rd),
            .disp_rob_idx (disp_rob_idx),
            .cmt_valid    (cmt_valid),
            .cmt_rd       (cmt_rd),
            .cmt_rob_idx  (cmt_rob_idx),
            .cmt_data     (cmt_data),
            .rdy          (src_rdy[j][0]),
            .tag          (src_tag[j][0]),
            .data         (src_data[j][0])
        );

        rat_src_lookup #(.SLOT(j)) u_rs2 (
            .src          (disp_rs2[j]),
            .entry        (rat_q[disp_rs2[j]]),
            .disp_valid   (disp_valid),
            .disp_rd      (disp_rd),
            .disp_rob_idx (disp_rob_idx),
            .cmt_valid    (cmt_valid),
            .cmt_rd       (cmt_rd),
            .cmt_rob_idx  (cmt_rob_idx),
            .cmt_data     (cmt_data),
            .rdy          (src_rdy[j][1]),
            .tag          (src_tag[j][1]),
            .data         (src_data[j][1])
        );
    end

    // Next table state: commits first, then flush or rename override readiness.
    always_comb begin
        rat_d = rat_q;

        // Data always lands; readiness only when the committer is the latest
        // writer. Ascending order lets higher commit slots win on the same rd.
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (cmt_valid[k] && (cmt_rd[k] != '0)) begin
                rat_d[cmt_rd[k]].data = cmt_data[k];
                if (cmt_rob_idx[k] == rat_q[cmt_rd[k]].rob_idx) begin
                    rat_d[cmt_rd[k]].ready = 1'b1;
                end
            end
        end

        if (flush) begin
            // Squashed writers will never commit, so every value is current.
            for (int r = 0; r < NUM_ARCH_REGS; r++) begin
                rat_d[r].ready = 1'b1;
            end
        end else begin
            // Ascending order lets the youngest slot own a shared rd.
            for (int j = 0; j < DISPATCH_WIDTH; j++) begin
                if (disp_valid[j] && (disp_rd[j] != '0)) begin
                    rat_d[disp_rd[j]].ready   = 1'b0;
                    rat_d[disp_rd[j]].rob_idx = disp_rob_idx[j];
                end
            end
        end

        rat_d[0] = RAT_ENTRY_RESET;
    end

    // Table register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: this storage is flops, not a RAM macro, and every entry must
        // come out of reset ready with zero data, so the whole array resets.
        if (rst) begin
            rat_q <= '{default: RAT_ENTRY_RESET};
        end else begin
            rat_q <= rat_d;
        end
    end

endmodule

// File: tb/tb_rat_arf_superscalar.sv
// Directed bench for rat_arf_superscalar: a register-level reference model
// is checked against every valid source on every cycle, with literal
// expectations at the key points of each scenario.
module tb_rat_arf_superscalar;
    import rv32i_types::*;

    localparam int D = DISPATCH_WIDTH;
    localparam int C = COMMIT_WIDTH;

    logic clk = 1'b0;
    logic rst;
    logic [D-1:0]                                disp_valid;
    logic [D-1:0][ARCH_REG_IDX_WIDTH-1:0]        disp_rs1, disp_rs2, disp_rd;
    logic [D-1:0][ROB_IDX_WIDTH-1:0]             disp_rob_idx;
    logic [C-1:0]                                cmt_valid;
    logic [C-1:0][ARCH_REG_IDX_WIDTH-1:0]        cmt_rd;
    logic [C-1:0][ROB_IDX_WIDTH-1:0]             cmt_rob_idx;
    logic [C-1:0][DATA_WIDTH-1:0]                cmt_data;
    logic                                        flush;
    logic [D-1:0][1:0]                           src_rdy;
    logic [D-1:0][1:0][ROB_IDX_WIDTH-1:0]        src_tag;
    logic [D-1:0][1:0][DATA_WIDTH-1:0]           src_data;

    int n_checks = 0;
    int n_pass   = 0;
    logic cmp_en = 1'b0;

    // Reference register file: value, current flag, latest writer tag.
    logic [DATA_WIDTH-1:0]    m_data  [NUM_ARCH_REGS];
    logic                     m_ready [NUM_ARCH_REGS];
    logic [ROB_IDX_WIDTH-1:0] m_tag   [NUM_ARCH_REGS];

    rat_arf_superscalar dut (
        .clk          (clk),
        .rst          (rst),
        .disp_valid   (disp_valid),
        .disp_rs1     (disp_rs1),
        .disp_rs2     (disp_rs2),
        .disp_rd      (disp_rd),
        .disp_rob_idx (disp_rob_idx),
        .cmt_valid    (cmt_valid),
        .cmt_rd       (cmt_rd),
        .cmt_rob_idx  (cmt_rob_idx),
        .cmt_data     (cmt_data),
        .flush        (flush),
        .src_rdy      (src_rdy),
        .src_tag      (src_tag),
        .src_data     (src_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // What a source must read: x0, else youngest older renamer in the group,
    // else a commit of the tag it waits on, else the register itself.
    function automatic void model_src(input int j, input logic [4:0] src,
                                      output logic rdy, output logic [4:0] tag,
                                      output logic [31:0] data);
        rdy = m_ready[src]; tag = m_tag[src]; data = m_data[src];
        if (src == 5'd0) begin
            rdy = 1'b1; tag = '0; data = '0;
            return;
        end
        for (int i = j - 1; i >= 0; i--) begin
            if (disp_valid[i] && disp_rd[i] == src) begin
                rdy = 1'b0; tag = disp_rob_idx[i];
                return;
            end
        end
        if (!m_ready[src]) begin
            for (int k = C - 1; k >= 0; k--) begin
                if (cmt_valid[k] && cmt_rd[k] == src && cmt_rob_idx[k] == m_tag[src]) begin
                    rdy = 1'b1; data = cmt_data[k];
                    return;
                end
            end
        end
    endfunction

    // Reference register-file update on each rising edge.
    always @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_ARCH_REGS; r++) begin
                m_data[r] = '0; m_ready[r] = 1'b1; m_tag[r] = '0;
            end
        end else begin
            logic [DATA_WIDTH-1:0]    nd [NUM_ARCH_REGS];
            logic                     nr [NUM_ARCH_REGS];
            logic [ROB_IDX_WIDTH-1:0] nt [NUM_ARCH_REGS];
            nd = m_data; nr = m_ready; nt = m_tag;
            for (int k = 0; k < C; k++) begin
                if (cmt_valid[k] && cmt_rd[k] != 0) begin
                    nd[cmt_rd[k]] = cmt_data[k];
                    if (cmt_rob_idx[k] == m_tag[cmt_rd[k]]) nr[cmt_rd[k]] = 1'b1;
                end
            end
            if (flush) begin
                for (int r = 0; r < NUM_ARCH_REGS; r++) nr[r] = 1'b1;
            end else begin
                for (int j = 0; j < D; j++) begin
                    if (disp_valid[j] && disp_rd[j] != 0) begin
                        nr[disp_rd[j]] = 1'b0; nt[disp_rd[j]] = disp_rob_idx[j];
                    end
                end
            end
            m_data = nd; m_ready = nr; m_tag = nt;
        end
    end

    // Every valid source is compared with the model mid-cycle.
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int j = 0; j < D; j++) begin
                for (int s = 0; s < 2; s++) begin
                    if (disp_valid[j]) begin
                        logic        er;
                        logic [4:0]  et;
                        logic [31:0] ed;
                        model_src(j, (s == 0) ? disp_rs1[j] : disp_rs2[j], er, et, ed);
                        check($sformatf("model_rdy_s%0d_%0d", j, s), 64'(src_rdy[j][s]), 64'(er));
                        if (er) check($sformatf("model_data_s%0d_%0d", j, s), 64'(src_data[j][s]), 64'(ed));
                        else    check($sformatf("model_tag_s%0d_%0d", j, s), 64'(src_tag[j][s]), 64'(et));
                    end
                end
            end
        end
    end

    task automatic clear_inputs();
        disp_valid = '0; disp_rs1 = '0; disp_rs2 = '0; disp_rd = '0; disp_rob_idx = '0;
        cmt_valid = '0; cmt_rd = '0; cmt_rob_idx = '0; cmt_data = '0; flush = 1'b0;
    endtask

    task automatic disp(input int j, input int rs1, input int rs2, input int rd, input int tag);
        disp_valid[j] = 1'b1;
        disp_rs1[j] = 5'(rs1); disp_rs2[j] = 5'(rs2);
        disp_rd[j] = 5'(rd); disp_rob_idx[j] = 5'(tag);
    endtask

    task automatic cmt(input int k, input int rd, input int tag, input logic [31:0] data);
        cmt_valid[k] = 1'b1;
        cmt_rd[k] = 5'(rd); cmt_rob_idx[k] = 5'(tag); cmt_data[k] = data;
    endtask

    // Move from drive time (edge+1) to the middle of the cycle.
    task automatic settle();
        #4;
    endtask

    // Cross the next edge and clear inputs just after it.
    task automatic next();
        @(posedge clk); #1;
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cmp_en = 1'b1;

        // Reset state through a lookup, including x0.
        disp(0, 5, 0, 0, 0);
        settle();
        check("reset_rdy_rs1", 64'(src_rdy[0][0]), 64'd1);
        check("reset_rdy_rs2", 64'(src_rdy[0][1]), 64'd1);
        check("reset_data_rs1", 64'(src_data[0][0]), 64'd0);
        check("reset_data_rs2", 64'(src_data[0][1]), 64'd0);
        next();

        // Intra-group rename: slot0 writes x3 tag 4, slot1 reads x3.
        disp(0, 0, 0, 3, 4);
        disp(1, 3, 0, 0, 0);
        settle();
        check("group_rdy", 64'(src_rdy[1][0]), 64'd0);
        check("group_tag", 64'(src_tag[1][0]), 64'd4);
        next();

        // Table now pending on tag 4; rename x3 again to tag 7.
        disp(0, 3, 0, 3, 7);
        settle();
        check("x3_pending_rdy", 64'(src_rdy[0][0]), 64'd0);
        check("x3_pending_tag", 64'(src_tag[0][0]), 64'd4);
        check("pin_model_x3_tag4", 64'(m_tag[3]), 64'd4);
        next();

        // Stale commit of tag 4 must not make x3 ready.
        cmt(0, 3, 4, 32'hAA);
        disp(0, 3, 0, 0, 0);
        settle();
        check("stale_cmt_rdy", 64'(src_rdy[0][0]), 64'd0);
        check("stale_cmt_tag", 64'(src_tag[0][0]), 64'd7);
        next();

        // Data took the stale value, still not ready; commit of tag 7 forwards.
        check("pin_model_x3_data", 64'(m_data[3]), 64'hAA);
        check("pin_model_x3_rdy", 64'(m_ready[3]), 64'd0);
        cmt(1, 3, 7, 32'hBB);
        disp(0, 3, 0, 0, 0);
        settle();
        check("latest_cmt_fwd_rdy", 64'(src_rdy[0][0]), 64'd1);
        check("latest_cmt_fwd_data", 64'(src_data[0][0]), 64'hBB);
        next();

        // x3 stored ready; set x6 pending on tag 2.
        disp(0, 3, 0, 6, 2);
        settle();
        check("x3_ready_rdy", 64'(src_rdy[0][0]), 64'd1);
        check("x3_ready_data", 64'(src_data[0][0]), 64'hBB);
        next();

        // Commit forward to rs2 of x6; meanwhile x9 goes pending on tag 1.
        cmt(0, 6, 2, 32'h55);
        disp(0, 0, 6, 0, 0);
        disp(1, 0, 0, 9, 1);
        settle();
        check("fwd_x6_rdy", 64'(src_rdy[0][1]), 64'd1);
        check("fwd_x6_data", 64'(src_data[0][1]), 64'h55);
        next();

        // Same-cycle matching commit and rename of x9.
        cmt(1, 9, 1, 32'h99);
        disp(0, 0, 0, 9, 8);
        disp(1, 9, 0, 0, 0);
        settle();
        check("x9_group_tag", 64'(src_tag[1][0]), 64'd8);
        next();

        disp(0, 9, 0, 0, 0);
        settle();
        check("x9_rename_wins_rdy", 64'(src_rdy[0][0]), 64'd0);
        check("x9_rename_wins_tag", 64'(src_tag[0][0]), 64'd8);
        check("pin_model_x9_data", 64'(m_data[9]), 64'h99);
        next();

        // Flush with a commit to x2 and a dispatch writing x4.
        flush = 1'b1;
        cmt(0, 2, 0, 32'h10);
        disp(0, 0, 0, 4, 3);
        next();

        disp(0, 3, 9, 0, 0);
        disp(1, 2, 4, 0, 0);
        settle();
        check("flush_x3_rdy", 64'(src_rdy[0][0]), 64'd1);
        check("flush_x9_rdy", 64'(src_rdy[0][1]), 64'd1);
        check("flush_x9_data", 64'(src_data[0][1]), 64'h99);
        check("flush_x2_data", 64'(src_data[1][0]), 64'h10);
        check("flush_x4_rdy", 64'(src_rdy[1][1]), 64'd1);
        check("flush_x4_data", 64'(src_data[1][1]), 64'd0);
        check("pin_model_x9_tag_kept", 64'(m_tag[9]), 64'd8);
        next();

        // Both slots rename x7 (slot1 wins); both commits write x8 (slot1 wins).
        disp(0, 0, 0, 7, 10);
        disp(1, 7, 0, 7, 11);
        cmt(0, 8, 0, 32'h1);
        cmt(1, 8, 0, 32'h2);
        settle();
        check("dup_group_tag", 64'(src_tag[1][0]), 64'd10);
        next();

        disp(0, 7, 8, 0, 0);
        settle();
        check("dup_rd_tag", 64'(src_tag[0][0]), 64'd11);
        check("dup_cmt_data", 64'(src_data[0][1]), 64'h2);
        next();

        // Writes to x0 are dropped.
        disp(0, 0, 0, 0, 5);
        cmt(0, 0, 0, 32'hDEAD);
        next();
        disp(0, 0, 0, 0, 0);
        settle();
        check("x0_rdy", 64'(src_rdy[0][0]), 64'd1);
        check("x0_data", 64'(src_data[0][0]), 64'd0);
        next();

        // Mid-operation reset overrides flush, rename and commit.
        disp(0, 0, 0, 5, 12);
        next();
        rst = 1'b1;
        flush = 1'b1;
        cmt(0, 6, 0, 32'h77);
        disp(0, 5, 0, 10, 13);
        settle();
        check("pre_reset_x5_tag", 64'(src_tag[0][0]), 64'd12);
        next();
        rst = 1'b0;
        for (int r = 0; r < NUM_ARCH_REGS; r++) begin
            disp(0, r, NUM_ARCH_REGS - 1 - r, 0, 0);
            settle();
            check($sformatf("post_reset_rdy_x%0d", r), 64'(src_rdy[0][0]), 64'd1);
            check($sformatf("post_reset_data_x%0d", r), 64'(src_data[0][0]), 64'd0);
            next();
        end

        // Mixed traffic on a few registers, checked against the model only.
        for (int n = 0; n < 80; n++) begin
            for (int j = 0; j < D; j++) begin
                if ($urandom_range(0, 3) != 0)
                    disp(j, $urandom_range(0, 7), $urandom_range(0, 7),
                         $urandom_range(0, 7), $urandom_range(0, 15));
            end
            for (int k = 0; k < C; k++) begin
                if ($urandom_range(0, 1) != 0) begin
                    int rd;
                    rd = $urandom_range(0, 7);
                    cmt(k, rd, ($urandom_range(0, 1) != 0) ? int'(m_tag[rd]) : $urandom_range(0, 15),
                        $urandom());
                end
            end
            flush = ($urandom_range(0, 15) == 0);
            next();
        end

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
